// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues inst SRAM reads and hands {inst, pc} to ID.
// Optional misaligned-fetch flag on bus bit 64 when FS_EXC_ADEF_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
`ifdef FS_EXC_ADEF_EN
  output logic [64:0] fs_to_ds_bus,
`else
  output logic [63:0] fs_to_ds_bus,
`endif
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic [31:0] inst_buf;
  logic        inst_buf_valid;
  logic        br_pending;
  logic [31:0] br_target_r;

  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        br_cancel;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign to_fs_valid = ~reset;
  assign fs_ready_go = 1'b1;
  assign fs_allowin  = ~fs_valid | (fs_ready_go & ds_allowin);
  assign br_cancel   = br_taken;

  // A live redirect beats a parked one, so the newest branch target always wins.
  always_comb begin
    nextpc = fs_pc + 32'd4;
    if (br_taken)
      nextpc = br_target;
    else if (br_pending)
      nextpc = br_target_r;
  end

  assign inst_sram_en    = to_fs_valid & fs_allowin;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_wdata = 32'h0;
`ifdef FS_EXC_ADEF_EN
  assign inst_sram_addr  = {nextpc[31:2], 2'b00};
`else
  assign inst_sram_addr  = nextpc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
    end else if (inst_sram_en) begin
      fs_valid <= 1'b1;
      fs_pc    <= nextpc;
    end else if (br_taken) begin
      fs_valid <= 1'b0;
    end
  end

  // A redirect that cannot issue while stalled is parked until IF can fetch again.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_pending  <= 1'b0;
      br_target_r <= 32'h0;
    end else if (inst_sram_en) begin
      br_pending  <= 1'b0;
    end else if (br_taken) begin
      br_pending  <= 1'b1;
      br_target_r <= br_target;
    end
  end

  // SRAM data is only valid one cycle after the read, so a stalled word is kept locally.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_buf_valid <= 1'b0;
      inst_buf       <= 32'h0;
    end else if (inst_sram_en || br_taken) begin
      inst_buf_valid <= 1'b0;
    end else if (fs_valid && !ds_allowin && !inst_buf_valid) begin
      inst_buf_valid <= 1'b1;
      inst_buf       <= inst_sram_rdata;
    end
  end

  assign fs_inst        = inst_buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_to_ds_valid = fs_valid & ~br_cancel;

`ifdef FS_EXC_ADEF_EN
  logic fs_adef;
  assign fs_adef      = (fs_pc[1:0] != 2'b00);
  assign fs_to_ds_bus = {fs_adef, (fs_adef ? 32'h0 : fs_inst), fs_pc};
`else
  assign fs_to_ds_bus = {fs_inst, fs_pc};
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed cycles push expected deliveries, a monitor checks them.
// Handles both default and FS_EXC_ADEF_EN builds.
module tb_if_stage;

`ifdef FS_EXC_ADEF_EN
  localparam int BW = 65;
`else
  localparam int BW = 64;
`endif

  logic          clk;
  logic          reset;
  logic          ds_allowin;
  logic          br_taken;
  logic [31:0]   br_target;
  logic          fs_to_ds_valid;
  logic [BW-1:0] fs_to_ds_bus;
  logic          inst_sram_en;
  logic          inst_sram_we;
  logic [31:0]   inst_sram_addr;
  logic [31:0]   inst_sram_wdata;
  logic [31:0]   inst_sram_rdata;

  int compared;
  int mismatched;
  int cyc;
  logic [64:0] exp_q[$];

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: returns the address as data except one marked word; garbage when idle
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1c000008) ? 32'hAAAA5555 : a;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (inst_sram_en)
      inst_sram_rdata <= mem_word(inst_sram_addr);
    else
      inst_sram_rdata <= 32'hDEAD0000 | 32'(cyc);
  end

  task automatic checkOutput(input string name, input logic [64:0] actual, input logic [64:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic allow, input logic br, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset      = rst;
    ds_allowin = allow;
    br_taken   = br;
    br_target  = tgt;
  endtask

  function automatic logic [64:0] deliv(input logic adef, input logic [31:0] inst, input logic [31:0] pc);
    return {adef, inst, pc};
  endfunction

  // Monitor: every accepted handshake pops one expected delivery
  always @(negedge clk) begin
    if (reset === 1'b0 && fs_to_ds_valid && ds_allowin) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_delivery: got %h expected none", fs_to_ds_bus);
      end else begin
        checkOutput("delivery", 65'(fs_to_ds_bus), exp_q.pop_front());
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    inst_sram_rdata = 32'h0;
    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_taken   = 1'b0;
    br_target  = 32'h0;

    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    @(negedge clk);
    checkOutput("reset_en", 65'(inst_sram_en), 65'd0);
    checkOutput("reset_valid", 65'(fs_to_ds_valid), 65'd0);

    exp_q.push_back(deliv(0, 32'h1c000000, 32'h1c000000));
    exp_q.push_back(deliv(0, 32'h1c000004, 32'h1c000004));
    exp_q.push_back(deliv(0, 32'hAAAA5555, 32'h1c000008));

    applyStimulus(0, 1, 0, 0);
    @(negedge clk);
    checkOutput("first_en", 65'(inst_sram_en), 65'd1);
    checkOutput("first_addr", 65'(inst_sram_addr), 65'h1c000000);
    checkOutput("we_tied", 65'(inst_sram_we), 65'd0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);

    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("stall_en", 65'(inst_sram_en), 65'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("stall_bus", 65'(fs_to_ds_bus), deliv(0, 32'hAAAA5555, 32'h1c000008));
      checkOutput("stall_en_hold", 65'(inst_sram_en), 65'd0);
      checkOutput("stall_valid", 65'(fs_to_ds_valid), 65'd1);
    end
    applyStimulus(0, 1, 0, 0);

    applyStimulus(0, 1, 1, 32'h1c000100);
    @(negedge clk);
    checkOutput("br_cancel_valid", 65'(fs_to_ds_valid), 65'd0);
    checkOutput("br_en", 65'(inst_sram_en), 65'd1);
    checkOutput("br_addr", 65'(inst_sram_addr), 65'h1c000100);
    exp_q.push_back(deliv(0, 32'h1c000100, 32'h1c000100));
    exp_q.push_back(deliv(0, 32'h1c000104, 32'h1c000104));
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);

    applyStimulus(0, 0, 1, 32'h1c000200);
    @(negedge clk);
    checkOutput("stall_br_valid", 65'(fs_to_ds_valid), 65'd0);
    checkOutput("stall_br_en", 65'(inst_sram_en), 65'd0);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("pending_valid", 65'(fs_to_ds_valid), 65'd0);
    checkOutput("pending_en", 65'(inst_sram_en), 65'd1);
    checkOutput("pending_addr", 65'(inst_sram_addr), 65'h1c000200);
    exp_q.push_back(deliv(0, 32'h1c000200, 32'h1c000200));
    exp_q.push_back(deliv(0, 32'h1c000204, 32'h1c000204));
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);

    applyStimulus(0, 1, 1, 32'hFFFFFFFC);
    @(negedge clk);
    checkOutput("wrap_br_addr", 65'(inst_sram_addr), 65'hFFFFFFFC);
    exp_q.push_back(deliv(0, 32'hFFFFFFFC, 32'hFFFFFFFC));
    exp_q.push_back(deliv(0, 32'h00000000, 32'h00000000));
    exp_q.push_back(deliv(0, 32'h00000004, 32'h00000004));
    applyStimulus(0, 1, 0, 0);
    @(negedge clk);
    checkOutput("wrap_addr", 65'(inst_sram_addr), 65'h00000000);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);

    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 1, 32'h1c000300);
    @(negedge clk);
    checkOutput("midreset_en", 65'(inst_sram_en), 65'd0);
    applyStimulus(1, 1, 0, 0);
    @(negedge clk);
    checkOutput("midreset_valid", 65'(fs_to_ds_valid), 65'd0);
    applyStimulus(0, 1, 0, 0);
    @(negedge clk);
    checkOutput("restart_addr", 65'(inst_sram_addr), 65'h1c000000);
    exp_q.push_back(deliv(0, 32'h1c000000, 32'h1c000000));
    applyStimulus(0, 1, 0, 0);

    applyStimulus(0, 1, 1, 32'h1c000102);
    @(negedge clk);
    checkOutput("unaligned_cancel", 65'(fs_to_ds_valid), 65'd0);
`ifdef FS_EXC_ADEF_EN
    checkOutput("adef_addr", 65'(inst_sram_addr), 65'h1c000100);
    exp_q.push_back(deliv(1, 32'h0, 32'h1c000102));
`else
    checkOutput("unaligned_addr", 65'(inst_sram_addr), 65'h1c000102);
    exp_q.push_back(deliv(0, 32'h1c000102, 32'h1c000102));
`endif
    applyStimulus(0, 1, 0, 0);

    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("queue_drained", 65'(exp_q.size()), 65'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
